// File: rtl/regfile_sb.sv
// regfile_sb: register file with a scoreboard of busy bits.
//
// Two combinational read ports (N1/Q1/B1, N2/Q2/B2), one write port
// (ND/DI/WE) and one reservation port (RN/RE). A reservation marks a
// register as having a pending producer. A write stores data and retires
// the reservation, unless a reservation for the same register lands on
// the same edge, because that reservation belongs to a newer producer.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   rst      - synchronous active-high reset
//   N1, N2   - read addresses
//   Q1, Q2   - read data (combinational, optional write bypass)
//   B1, B2   - busy flag of the addressed register
//   ND/DI/WE - write address / data / enable
//   RN/RE    - reserve address / enable
//   busy_cnt - registered count of busy registers
//   err      - sticky flag: reservation made on an already busy register
module regfile_sb #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 5,
  parameter int                 ZERO_REG  = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}},
  parameter int                 BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] N1,
  input  logic [ADDR_W-1:0] N2,
  output logic [DATA_W-1:0] Q1,
  output logic [DATA_W-1:0] Q2,
  output logic              B1,
  output logic              B2,
  input  logic [ADDR_W-1:0] ND,
  input  logic [DATA_W-1:0] DI,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RN,
  input  logic              RE,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              err_q, err_d;

  logic we_eff_s, re_eff_s;
  logic inc_s, dec_s;

  // Qualify write/reserve: register 0 drops both when it is hard-wired.
  always_comb begin
    we_eff_s = WE;
    re_eff_s = RE;
    if ((ZERO_REG != 0) && (ND == {ADDR_W{1'b0}})) begin
      we_eff_s = 1'b0;
    end else begin
      we_eff_s = WE;
    end
    if ((ZERO_REG != 0) && (RN == {ADDR_W{1'b0}})) begin
      re_eff_s = 1'b0;
    end else begin
      re_eff_s = RE;
    end
  end

  // Scoreboard next state. The write clears first so a same-edge
  // reservation to the same register leaves it busy.
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    err_d      = err_q;
    // Count moves only on a real 0->1 or 1->0 transition of a busy bit.
    inc_s = re_eff_s && !busy_q[RN];
    dec_s = we_eff_s && busy_q[ND] && !(re_eff_s && (RN == ND));
    if (we_eff_s) begin
      busy_d[ND] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (re_eff_s) begin
      busy_d[RN] = 1'b1;
    end else begin
      busy_d[RN] = busy_d[RN];
    end
    if (inc_s && !dec_s) begin
      busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    end else if (dec_s && !inc_s) begin
      busy_cnt_d = busy_cnt_q - {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
    // Double reservation is an error unless the same edge retires it.
    if (re_eff_s && busy_q[RN] && !(we_eff_s && (ND == RN))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Register array, busy bits, busy count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      busy_q     <= {DEPTH{1'b0}};
      busy_cnt_q <= {(ADDR_W+1){1'b0}};
      err_q      <= 1'b0;
    end else begin
      if (we_eff_s) begin
        regs_q[ND] <= DI;
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_d;
    end
  end

  // Read ports: hard-wired zero first, then bypass, then stored state.
  always_comb begin
    Q1 = regs_q[N1];
    B1 = busy_q[N1];
    Q2 = regs_q[N2];
    B2 = busy_q[N2];
    if ((ZERO_REG != 0) && (N1 == {ADDR_W{1'b0}})) begin
      Q1 = {DATA_W{1'b0}};
      B1 = 1'b0;
    end else if ((BYPASS != 0) && we_eff_s && (ND == N1)) begin
      Q1 = DI;
      B1 = 1'b0;
    end else begin
      Q1 = regs_q[N1];
      B1 = busy_q[N1];
    end
    if ((ZERO_REG != 0) && (N2 == {ADDR_W{1'b0}})) begin
      Q2 = {DATA_W{1'b0}};
      B2 = 1'b0;
    end else if ((BYPASS != 0) && we_eff_s && (ND == N2)) begin
      Q2 = DI;
      B2 = 1'b0;
    end else begin
      Q2 = regs_q[N2];
      B2 = busy_q[N2];
    end
  end

  assign busy_cnt = busy_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] N1, N2, ND, RN;
  logic [DW-1:0] Q1, Q2, DI;
  logic          B1, B2, WE, RE;
  logic [AW:0]   busy_cnt;
  logic          err;

  regfile_sb #(
    .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1),
    .RESET_VAL(32'd1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .N1(N1), .N2(N2), .Q1(Q1), .Q2(Q2), .B1(B1), .B2(B2),
    .ND(ND), .DI(DI), .WE(WE), .RN(RN), .RE(RE),
    .busy_cnt(busy_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sel;   // 0=Q1 1=Q2 2=B1 3=B2 4=busy_cnt 5=err
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return Q1;
      1: return Q2;
      2: return {31'd0, B1};
      3: return {31'd0, B2};
      4: return {26'd0, busy_cnt};
      default: return {31'd0, err};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model
  logic [DW-1:0] m_regs [DEPTH];
  logic          m_busy [DEPTH];
  logic          m_err;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = 32'd1;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_read(input logic [AW-1:0] n, output logic [31:0] q, output logic b);
    if (n == 5'd0) begin
      q = 32'd0; b = 1'b0;
    end else if (WE && ND == n) begin
      q = DI; b = 1'b0;
    end else begin
      q = m_regs[n]; b = m_busy[n];
    end
  endtask

  task automatic m_edge();
    logic old_b;
    if (rst) begin
      m_reset();
    end else begin
      old_b = m_busy[RN];
      if (WE && ND != 5'd0) begin
        m_regs[ND] = DI;
        m_busy[ND] = 1'b0;
      end
      if (RE && RN != 5'd0) begin
        if (old_b && !(WE && ND == RN)) m_err = 1'b1;
        m_busy[RN] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    WE = 1'b0; RE = 1'b0; ND = 5'd0; RN = 5'd0; DI = 32'd0;
  endtask

  initial begin
    logic [31:0] q;
    logic        b;
    rst = 1'b1; N1 = 5'd0; N2 = 5'd0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset state with RESET_VAL=1
    N1 = 5'd5; N2 = 5'd0;
    push("rst_q1", 0, 32'd1); push("rst_q2", 1, 32'd0);
    push("rst_b1", 2, 32'd0); push("rst_b2", 3, 32'd0);
    push("rst_cnt", 4, 32'd0); push("rst_err", 5, 32'd0);
    drain();

    // Reserve 3, then write it with bypass
    RE = 1'b1; RN = 5'd3;
    step();
    RE = 1'b0; N1 = 5'd3;
    push("res3_b1", 2, 32'd1); push("res3_cnt", 4, 32'd1);
    drain();
    WE = 1'b1; ND = 5'd3; DI = 32'hDEADBEEF;
    push("byp3_q1", 0, 32'hDEADBEEF); push("byp3_b1", 2, 32'd0);
    drain();
    step();
    idle();
    push("wr3_cnt", 4, 32'd0); push("wr3_q1", 0, 32'hDEADBEEF); push("wr3_b1", 2, 32'd0);
    drain();

    // Same-edge reserve and write to 7: reservation wins
    RE = 1'b1; WE = 1'b1; RN = 5'd7; ND = 5'd7; DI = 32'h55; N1 = 5'd7;
    push("rw7_byp_q1", 0, 32'h55); push("rw7_byp_b1", 2, 32'd0);
    drain();
    step();
    idle();
    push("rw7_q1", 0, 32'h55); push("rw7_b1", 2, 32'd1);
    push("rw7_cnt", 4, 32'd1); push("rw7_err", 5, 32'd0);
    drain();
    WE = 1'b1; ND = 5'd7; DI = 32'h66;
    step();
    idle();
    push("clr7_cnt", 4, 32'd0);
    drain();

    // Double reservation of 9
    RE = 1'b1; RN = 5'd9;
    step();
    step();
    idle(); N1 = 5'd9;
    push("dbl9_err", 5, 32'd1); push("dbl9_cnt", 4, 32'd1); push("dbl9_b1", 2, 32'd1);
    drain();
    WE = 1'b1; ND = 5'd9; DI = 32'hA5;
    step();
    idle();
    push("wr9_cnt", 4, 32'd0); push("wr9_err", 5, 32'd1);
    drain();

    // Register 0 ignores writes and reservations
    WE = 1'b1; ND = 5'd0; DI = 32'h1234; RE = 1'b1; RN = 5'd0; N1 = 5'd0;
    push("z0_byp_q1", 0, 32'd0); push("z0_byp_b1", 2, 32'd0);
    drain();
    step();
    idle();
    push("z0_q1", 0, 32'd0); push("z0_b1", 2, 32'd0); push("z0_cnt", 4, 32'd0);
    drain();

    // Reserve 1,2,4 then reset with a write outstanding
    RE = 1'b1; RN = 5'd1; step();
    RN = 5'd2; step();
    RN = 5'd4; step();
    idle();
    push("res3x_cnt", 4, 32'd3);
    drain();
    rst = 1'b1; WE = 1'b1; ND = 5'd2; DI = 32'h77; N1 = 5'd2; N2 = 5'd1;
    push("rstcyc_q1", 0, 32'h77); push("rstcyc_b2", 3, 32'd1);
    drain();
    step();
    rst = 1'b0; idle();
    push("post_cnt", 4, 32'd0); push("post_err", 5, 32'd0);
    push("post_q1", 0, 32'd1); push("post_b1", 2, 32'd0);
    push("post_q2", 1, 32'd1); push("post_b2", 3, 32'd0);
    drain();

    // Random traffic against the reference model
    m_reset();
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      WE  = $urandom_range(0, 1);
      RE  = $urandom_range(0, 1);
      ND  = 5'($urandom_range(0, 7));
      RN  = 5'($urandom_range(0, 7));
      N1  = 5'($urandom_range(0, 7));
      N2  = 5'($urandom_range(0, 31));
      DI  = $urandom;
      m_read(N1, q, b);
      push("rnd_q1", 0, q); push("rnd_b1", 2, {31'd0, b});
      m_read(N2, q, b);
      push("rnd_q2", 1, q); push("rnd_b2", 3, {31'd0, b});
      drain();
      m_edge();
      step();
      rst = 1'b0;
      push("rnd_cnt", 4, m_cnt()); push("rnd_err", 5, {31'd0, m_err});
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
